// File: rtl/draw_pkg.sv
// draw_pkg: shared coordinate width, span-generator FSM encoding and writer SPI commands.
package draw_pkg;
  localparam int COORD_W = 9;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_EMIT,
    S_WAIT,
    S_FIN
  } span_state_t;
endpackage

// File: rtl/line_step_calc.sv
// line_step_calc: one combinational Bresenham step from the current pixel and error term.
module line_step_calc #(
  parameter int W  = 9,
  parameter int EW = W + 2
) (
  input  logic [W-1:0]         x_i,
  input  logic [W-1:0]         y_i,
  input  logic signed [EW-1:0] err_i,
  input  logic signed [EW-1:0] dx_i,
  input  logic signed [EW-1:0] dy_i,
  input  logic                 sx_i,
  input  logic                 sy_i,
  output logic [W-1:0]         nx_o,
  output logic [W-1:0]         ny_o,
  output logic signed [EW-1:0] nerr_o,
  output logic                 y_changed_o
);
  logic signed [EW-1:0] e2;
  logic step_x, step_y;
  always_comb begin
    e2          = err_i <<< 1;
    step_x      = e2 >= dy_i;
    step_y      = e2 <= dx_i;
    nx_o        = step_x ? (sx_i ? x_i - 1'b1 : x_i + 1'b1) : x_i;
    ny_o        = step_y ? (sy_i ? y_i - 1'b1 : y_i + 1'b1) : y_i;
    nerr_o      = err_i + (step_x ? dy_i : '0) + (step_y ? dx_i : '0);
    y_changed_o = step_y;
  end
endmodule

// File: rtl/line_span_gen.sv
// line_span_gen: walks a segment with Bresenham and hands each same-row run to the span writer.
module line_span_gen
  import draw_pkg::*;
#(
  parameter int W  = COORD_W,
  parameter int EW = W + 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_x0,
  input  logic [W-1:0] i_y0,
  input  logic [W-1:0] i_x1,
  input  logic [W-1:0] i_y1,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_span_start,
  output logic [W-1:0] o_span_x1,
  output logic [W-1:0] o_span_x2,
  output logic [W-1:0] o_span_y,
  input  logic         i_span_done
);
  span_state_t state_q;
  logic [W-1:0] x0_q, y0_q, x1_q, y1_q, cx_q, cy_q, run_lo_q, run_hi_q, run_y_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic sx_q, sy_q, last_q;
  logic signed [EW-1:0] ddx_d, ddy_d, dx_d, dy_d, nerr_d;
  logic [W-1:0] nx_d, ny_d;
  logic y_chg_d;
  always_comb begin
    ddx_d = $signed(EW'(x1_q)) - $signed(EW'(x0_q));
    ddy_d = $signed(EW'(y1_q)) - $signed(EW'(y0_q));
    dx_d  = ddx_d < 0 ? -ddx_d : ddx_d;
    dy_d  = ddy_d < 0 ? ddy_d : -ddy_d;
  end
  line_step_calc #(.W(W), .EW(EW)) u_step (
    .x_i        (cx_q),
    .y_i        (cy_q),
    .err_i      (err_q),
    .dx_i       (dx_q),
    .dy_i       (dy_q),
    .sx_i       (sx_q),
    .sy_i       (sy_q),
    .nx_o       (nx_d),
    .ny_o       (ny_d),
    .nerr_o     (nerr_d),
    .y_changed_o(y_chg_d)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      {x0_q, y0_q, x1_q, y1_q, cx_q, cy_q} <= '0;
      {run_lo_q, run_hi_q, run_y_q} <= '0;
      {dx_q, dy_q, err_q} <= '0;
      {sx_q, sy_q, last_q} <= '0;
      {o_busy, o_done, o_span_start} <= '0;
      {o_span_x1, o_span_x2, o_span_y} <= '0;
    end else begin
      o_span_start <= 1'b0;
      o_done       <= 1'b0;
      case (state_q)
        S_IDLE: if (i_start) begin
          {x0_q, y0_q, x1_q, y1_q} <= {i_x0, i_y0, i_x1, i_y1};
          o_busy  <= 1'b1;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          dx_q     <= dx_d;
          dy_q     <= dy_d;
          sx_q     <= ddx_d < 0;
          sy_q     <= ddy_d < 0;
          err_q    <= dx_d + dy_d;
          cx_q     <= x0_q;
          cy_q     <= y0_q;
          run_lo_q <= x0_q;
          run_hi_q <= x0_q;
          run_y_q  <= y0_q;
          state_q  <= S_STEP;
        end
        S_STEP: if (cx_q == x1_q && cy_q == y1_q) begin
          last_q  <= 1'b1;
          state_q <= S_EMIT;
        end else begin
          cx_q  <= nx_d;
          cy_q  <= ny_d;
          err_q <= nerr_d;
          // A row change closes the current run; the new pixel seeds the next one after WAIT.
          if (y_chg_d) begin
            last_q  <= 1'b0;
            state_q <= S_EMIT;
          end else begin
            run_lo_q <= nx_d < run_lo_q ? nx_d : run_lo_q;
            run_hi_q <= nx_d > run_hi_q ? nx_d : run_hi_q;
          end
        end
        S_EMIT: begin
          o_span_x1    <= run_lo_q;
          o_span_x2    <= run_hi_q;
          o_span_y     <= run_y_q;
          o_span_start <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: if (i_span_done) begin
          if (last_q) state_q <= S_FIN;
          else begin
            run_lo_q <= cx_q;
            run_hi_q <= cx_q;
            run_y_q  <= cy_q;
            state_q  <= S_STEP;
          end
        end
        S_FIN: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_span_gen.sv
// tb_line_span_gen: scoreboard bench; expected spans are queued, a monitor pops them on each o_span_start.
module tb_line_span_gen;
  localparam int W = 9;
  typedef struct packed {
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] y;
  } span_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, span_done = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic busy, done, span_start;
  logic [W-1:0] sx1, sx2, sy;
  span_t exp_q[$];
  int checks = 0, errors = 0, n_starts = 0, cyc = 0, t_first = -1, wr_delay = 4;
  line_span_gen #(.W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1),
    .o_busy(busy), .o_done(done), .o_span_start(span_start),
    .o_span_x1(sx1), .o_span_x2(sx2), .o_span_y(sy),
    .i_span_done(span_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input int a, input int b, input int y);
    span_t s;
    s.x1 = W'(a); s.x2 = W'(b); s.y = W'(y);
    exp_q.push_back(s);
  endtask
  always @(negedge clk) begin
    span_t e;
    if (span_start) begin
      n_starts = n_starts + 1;
      if (t_first < 0) t_first = cyc;
      if (exp_q.size() == 0) chk("unexpected_span", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("span_x1", int'(sx1), int'(e.x1));
        chk("span_x2", int'(sx2), int'(e.x2));
        chk("span_y", int'(sy), int'(e.y));
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (span_start) begin
      for (int k = 0; k < wr_delay && rst_n; k++) @(negedge clk);
      if (rst_n) begin
        span_done = 1'b1;
        @(negedge clk);
        span_done = 1'b0;
      end
    end
  end
  task automatic issue(input int ax, input int ay, input int bx, input int by, output int t0);
    @(negedge clk);
    x0 = W'(ax); y0 = W'(ay); x1 = W'(bx); y1 = W'(by);
    start = 1'b1;
    t_first = -1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", int'(busy), 1);
  endtask
  task automatic wait_done(input string nm);
    bit got = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk(nm, int'(got), 1);
    @(negedge clk);
    chk("busy_low", int'(busy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask
  task automatic run_seg(input int ax, input int ay, input int bx, input int by, input int n_exp);
    int t0, s0;
    s0 = n_starts;
    issue(ax, ay, bx, by, t0);
    wait_done("done_seen");
    chk("start_count", n_starts - s0, n_exp);
  endtask
  initial begin
    int t0, s0, bad;
    bit got;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_start", int'(span_start), 0);
    chk("rst_span", int'({sx1, sx2, sy}), 0);
    rst_n = 1'b1;
    push(10, 10, 20);
    run_seg(10, 20, 10, 20, 1);
    push(5, 12, 7);
    s0 = n_starts;
    issue(5, 7, 12, 7, t0);
    wait_done("done_horiz");
    chk("start_count_horiz", n_starts - s0, 1);
    chk("latency_le_3_plus_dx", int'(t_first - t0 - 1 <= 3 + 7), 1);
    push(5, 12, 7);
    run_seg(12, 7, 5, 7, 1);
    for (int r = 0; r < 4; r++) push(3, 3, r);
    run_seg(3, 0, 3, 3, 4);
    push(0, 1, 0); push(2, 5, 1); push(6, 7, 2);
    run_seg(0, 0, 7, 2, 3);
    wr_delay = 100;
    push(20, 25, 30);
    s0 = n_starts;
    issue(20, 30, 25, 30, t0);
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = span_start;
    end
    chk("hold_first_start", int'(got), 1);
    bad = 0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      start = (k == 40);
      if (k == 40) begin x0 = 1; y0 = 1; x1 = 2; y1 = 1; end
      if (span_start || !busy || sx1 != 20 || sx2 != 25 || sy != 30) bad++;
    end
    start = 1'b0;
    chk("hold_stable", bad, 0);
    wait_done("done_hold");
    repeat (10) @(negedge clk);
    chk("ignored_start_busy", int'(busy), 0);
    chk("start_count_hold", n_starts - s0, 1);
    push(4, 9, 4);
    issue(4, 4, 9, 4, t0);
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = span_start;
    end
    chk("rst_wait_start", int'(got), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_start", int'(span_start), 0);
    chk("midrst_span", int'({sx1, sx2, sy}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_delay = 4;
    push(1, 2, 1);
    run_seg(1, 1, 2, 1, 1);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
